// File: rtl/shiftregister_pkg.sv
// Shared mode and state encodings for the universal shift register.
package shiftregister_pkg;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned STATE_W = 2;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b110;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shiftregister_step.sv
// Combinational next-value function: one shift/rotate/load operation on q.
module shiftregister_step
  import shiftregister_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              serial_right_i,
  input  logic              serial_left_i,
  input  logic [WIDTH-1:0]  preset_i,
  output logic [WIDTH-1:0]  q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (mode_i)
      MODE_SHR:  q_next_o = {serial_right_i, q_i[WIDTH-1:1]};
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], serial_left_i};
      MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_LOAD: q_next_o = preset_i;
      default:   q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/shiftregister_universal.sv
// Universal shift register with parallel load and a burst sequencer that
// repeats one latched operation burst_count times from a single start pulse.
module shiftregister_universal
  import shiftregister_pkg::*;
#(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clockpulse,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [MODE_W-1:0]      mode,
  input  logic                   serial_input_right,
  input  logic                   serial_input_left,
  input  logic                   preset_enable,
  input  logic [WIDTH-1:0]       preset,
  input  logic                   burst_start,
  input  logic [COUNT_WIDTH-1:0] burst_count,
  output logic [WIDTH-1:0]       signal_q,
  output logic [WIDTH-1:0]       signal_q_,
  output logic                   serial_output_right,
  output logic                   serial_output_left,
  output logic                   busy,
  output logic                   done
);

  state_e                 state_q;
  logic [WIDTH-1:0]       q_q, qn_q, q_d, step_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [MODE_W-1:0]      burst_mode_q, op_mode;
  logic                   busy_q, done_q;

  assign op_mode = (state_q == ST_RUN) ? burst_mode_q : mode;

  shiftregister_step #(.WIDTH(WIDTH)) u_step (
    .q_i            (q_q),
    .mode_i         (op_mode),
    .serial_right_i (serial_input_right),
    .serial_left_i  (serial_input_left),
    .preset_i       (preset),
    .q_next_o       (step_q)
  );

  // Data path priority: load, then burst operation, then a single IDLE operation.
  always_comb begin
    q_d = q_q;
    if (preset_enable) begin
      q_d = preset;
    end else if (state_q == ST_RUN) begin
      q_d = step_q;
    end else if (state_q == ST_IDLE && !burst_start && enable) begin
      q_d = step_q;
    end
  end

  always_ff @(posedge clockpulse) begin
    if (!clear) begin
      q_q          <= '0;
      qn_q         <= '1;
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      burst_mode_q <= MODE_HOLD;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      q_q  <= q_d;
      qn_q <= ~q_d;
      if (preset_enable) begin
        // Load aborts any burst silently.
        state_q     <= ST_IDLE;
        remaining_q <= '0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            done_q <= 1'b0;
            if (burst_start) begin
              if (burst_count != '0) begin
                burst_mode_q <= mode;
                remaining_q  <= burst_count;
                state_q      <= ST_RUN;
                busy_q       <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign signal_q            = q_q;
  assign signal_q_           = qn_q;
  assign serial_output_right = q_q[0];
  assign serial_output_left  = q_q[WIDTH-1];
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_shiftregister_universal.sv
// Directed self-checking bench for the universal shift register (WIDTH=6).
module tb_shiftregister_universal;

  logic       clockpulse = 1'b0;
  logic       clear, enable, serial_input_right, serial_input_left;
  logic       preset_enable, burst_start;
  logic [2:0] mode;
  logic [5:0] preset;
  logic [3:0] burst_count;
  logic [5:0] signal_q, signal_q_;
  logic       serial_output_right, serial_output_left, busy, done;

  int checks = 0;
  int failures = 0;

  shiftregister_universal #(.WIDTH(6), .COUNT_WIDTH(4)) dut (
    .clockpulse          (clockpulse),
    .clear               (clear),
    .enable              (enable),
    .mode                (mode),
    .serial_input_right  (serial_input_right),
    .serial_input_left   (serial_input_left),
    .preset_enable       (preset_enable),
    .preset              (preset),
    .burst_start         (burst_start),
    .burst_count         (burst_count),
    .signal_q            (signal_q),
    .signal_q_           (signal_q_),
    .serial_output_right (serial_output_right),
    .serial_output_left  (serial_output_left),
    .busy                (busy),
    .done                (done)
  );

  always #5 clockpulse = ~clockpulse;

  task automatic tick();
    @(posedge clockpulse);
    #1;
  endtask

  task automatic load(input logic [5:0] v);
    preset_enable = 1'b1;
    preset = v;
    tick();
    preset_enable = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0; preset_enable = 1'b1; preset = 6'b111111;
    enable = 1'b1; mode = 3'b001; burst_start = 1'b1; burst_count = 4'd3;
    tick();
    checks++;
    if (signal_q !== 6'b000000 || signal_q_ !== 6'b111111 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%b qn=%b busy=%b done=%b, want 000000 111111 0 0",
               signal_q, signal_q_, busy, done);
    end
    clear = 1'b1; preset_enable = 1'b0; enable = 1'b0; burst_start = 1'b0; mode = 3'b000;
  endtask

  task automatic test_shifts();
    load(6'b101100);
    checks++;
    if (signal_q !== 6'b101100 || signal_q_ !== 6'b010011) begin
      failures++;
      $display("FAIL load: q=%b qn=%b, want 101100 010011", signal_q, signal_q_);
    end
    enable = 1'b1; mode = 3'b001; serial_input_right = 1'b1;
    tick();
    checks++;
    if (signal_q !== 6'b110110) begin
      failures++;
      $display("FAIL shr: q=%b, want 110110", signal_q);
    end
    mode = 3'b010; serial_input_left = 1'b0;
    tick();
    checks++;
    if (signal_q !== 6'b101100) begin
      failures++;
      $display("FAIL shl: q=%b, want 101100", signal_q);
    end
    checks++;
    if (serial_output_right !== 1'b0 || serial_output_left !== 1'b1) begin
      failures++;
      $display("FAIL serial_out: right=%b left=%b, want 0 1", serial_output_right, serial_output_left);
    end
    enable = 1'b0;
  endtask

  task automatic test_rotate_asr();
    load(6'b000001);
    enable = 1'b1; mode = 3'b011;
    tick();
    checks++;
    if (signal_q !== 6'b100000) begin
      failures++;
      $display("FAIL ror: q=%b, want 100000", signal_q);
    end
    mode = 3'b100;
    tick();
    checks++;
    if (signal_q !== 6'b000001) begin
      failures++;
      $display("FAIL rol_wrap: q=%b, want 000001", signal_q);
    end
    enable = 1'b0;
    load(6'b100100);
    enable = 1'b1; mode = 3'b101;
    tick();
    checks++;
    if (signal_q !== 6'b110010) begin
      failures++;
      $display("FAIL asr: q=%b, want 110010", signal_q);
    end
    mode = 3'b111;
    tick();
    checks++;
    if (signal_q !== 6'b110010) begin
      failures++;
      $display("FAIL reserved_hold: q=%b, want 110010", signal_q);
    end
    mode = 3'b000;
    tick();
    checks++;
    if (signal_q !== 6'b110010) begin
      failures++;
      $display("FAIL hold: q=%b, want 110010", signal_q);
    end
    mode = 3'b110; preset = 6'b010101;
    tick();
    checks++;
    if (signal_q !== 6'b010101 || signal_q_ !== 6'b101010) begin
      failures++;
      $display("FAIL mode_load: q=%b qn=%b, want 010101 101010", signal_q, signal_q_);
    end
    enable = 1'b0; mode = 3'b000;
  endtask

  task automatic test_burst();
    logic [5:0] exp_q [3];
    exp_q[0] = 6'b000010; exp_q[1] = 6'b000100; exp_q[2] = 6'b001000;
    load(6'b000001);
    mode = 3'b100; burst_start = 1'b1; burst_count = 4'd3; enable = 1'b1;
    tick();
    checks++;
    if (signal_q !== 6'b000001 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL burst_start: q=%b busy=%b done=%b, want 000001 1 0", signal_q, busy, done);
    end
    burst_start = 1'b0; enable = 1'b0; mode = 3'b001; serial_input_right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (signal_q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
        failures++;
        $display("FAIL burst_step%0d: q=%b busy=%b done=%b, want %b %b %b",
                 i, signal_q, busy, done, exp_q[i], (i < 2), (i == 2));
      end
    end
    tick();
    checks++;
    if (signal_q !== 6'b001000 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL burst_after: q=%b busy=%b done=%b, want 001000 0 0", signal_q, busy, done);
    end
    mode = 3'b000;
  endtask

  task automatic test_abort();
    load(6'b000001);
    mode = 3'b010; serial_input_left = 1'b1; burst_start = 1'b1; burst_count = 4'd5;
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    checks++;
    if (signal_q !== 6'b000111 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: q=%b busy=%b, want 000111 1", signal_q, busy);
    end
    preset_enable = 1'b1; preset = 6'b111111;
    tick();
    preset_enable = 1'b0;
    checks++;
    if (signal_q !== 6'b111111 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort: q=%b busy=%b done=%b, want 111111 0 0", signal_q, busy, done);
    end
    serial_input_left = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || signal_q !== 6'b111111) begin
        failures++;
        $display("FAIL abort_quiet%0d: q=%b busy=%b done=%b, want 111111 0 0", i, signal_q, busy, done);
      end
    end
    mode = 3'b000;
  endtask

  task automatic test_zero_count();
    load(6'b011010);
    mode = 3'b001; burst_start = 1'b1; burst_count = 4'd0; enable = 1'b1;
    tick();
    burst_start = 1'b0; enable = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || signal_q !== 6'b011010) begin
      failures++;
      $display("FAIL zero_done: q=%b busy=%b done=%b, want 011010 0 1", signal_q, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || signal_q !== 6'b011010) begin
      failures++;
      $display("FAIL zero_after: q=%b done=%b, want 011010 0", signal_q, done);
    end
    mode = 3'b000;
  endtask

  task automatic test_clear_mid();
    load(6'b000001);
    mode = 3'b100; burst_start = 1'b1; burst_count = 4'd5;
    tick();
    burst_start = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    checks++;
    if (signal_q !== 6'b000000 || signal_q_ !== 6'b111111 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL clear_mid: q=%b qn=%b busy=%b done=%b, want 000000 111111 0 0",
               signal_q, signal_q_, busy, done);
    end
    // Only an IDLE register honours enable/mode.
    enable = 1'b1; mode = 3'b110; preset = 6'b001010;
    tick();
    enable = 1'b0;
    checks++;
    if (signal_q !== 6'b001010 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: q=%b busy=%b done=%b, want 001010 0 0", signal_q, busy, done);
    end
    mode = 3'b000;
  endtask

  task automatic test_back_to_back();
    load(6'b000011);
    mode = 3'b011; burst_start = 1'b1; burst_count = 4'd1;
    tick();
    tick();
    checks++;
    if (signal_q !== 6'b100001 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: q=%b busy=%b done=%b, want 100001 0 1", signal_q, busy, done);
    end
    tick();
    checks++;
    if (signal_q !== 6'b100001 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_ignore: q=%b busy=%b done=%b, want 100001 0 0", signal_q, busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || signal_q !== 6'b100001) begin
      failures++;
      $display("FAIL b2b_restart: q=%b busy=%b, want 100001 1", signal_q, busy);
    end
    burst_start = 1'b0;
    tick();
    checks++;
    if (signal_q !== 6'b110000 || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: q=%b done=%b, want 110000 1", signal_q, done);
    end
    mode = 3'b000;
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; mode = 3'b000;
    serial_input_right = 1'b0; serial_input_left = 1'b0;
    preset_enable = 1'b0; preset = '0; burst_start = 1'b0; burst_count = '0;
    #2;
    test_reset();
    test_shifts();
    test_rotate_asr();
    test_burst();
    test_abort();
    test_zero_count();
    test_clear_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shiftregister_universal.md
Name: shiftregister_universal

Overview:
Parametrised universal shift register, the successor to the fixed 6-bit right-shift register. It adds selectable width, left/right shift, rotate, arithmetic shift and synchronous parallel load. A burst sequencer performs N consecutive operations from a single start pulse, with busy/done status. It is used by lab datapaths (serialisers, LFSR and multiplier experiments) that need a bank of shift stages driven by one controller.

Parameters:
WIDTH, 6, number of register bits (≥2).
COUNT_WIDTH, 4, width of burst_count. Maximum burst is 2^COUNT_WIDTH-1 operations.

Ports:
clockpulse  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous active-low reset.
enable  input  1  in IDLE, applies mode this cycle.
mode  input  3  operation select; encoding is in Behaviour.
serial_input_right  input  1  bit entering the MSB on shift right.
serial_input_left  input  1  bit entering the LSB on shift left.
preset_enable  input  1  synchronous parallel load; highest priority after clear.
preset  input  WIDTH  load value.
burst_start  input  1  start a burst (sampled in IDLE only).
burst_count  input  COUNT_WIDTH  number of operations in the burst.
signal_q  output  WIDTH  register contents.
signal_q_  output  WIDTH  bitwise complement of signal_q.
serial_output_right  output  1  signal_q[0], combinational.
serial_output_left  output  1  signal_q[WIDTH-1], combinational.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (clear=0 at an edge): signal_q=0, signal_q_=all ones, state=IDLE, busy=0, done=0, remaining=0. Reset overrides every other input.
- Mode encoding:
  - 000 hold.
  - 001 shift right: q <= {serial_input_right, q[W-1:1]}.
  - 010 shift left: q <= {q[W-2:0], serial_input_left}.
  - 011 rotate right: q <= {q[0], q[W-1:1]}.
  - 100 rotate left: q <= {q[W-2:0], q[W-1]}.
  - 101 arithmetic shift right: q <= {q[W-1], q[W-1:1]}.
  - 110 load preset.
  - 111 hold (reserved).
- Priority per edge: clear > preset_enable > burst sequencer > enable/mode.
- preset_enable=1: q <= preset in any state. If a burst is in progress, it is aborted: state goes to IDLE, busy=0, done is not asserted.
- States:
  - IDLE:
    - If burst_start=1 and burst_count>0: latch mode into burst_mode, set remaining=burst_count, go to RUN. No operation is applied on this edge.
    - If burst_start=1 and burst_count=0: go to DONE, q unchanged.
    - Otherwise, if enable=1: apply mode to q.
    - When burst_start=1, enable is ignored on that edge.
  - RUN (busy=1): each edge applies burst_mode and decrements remaining. When remaining goes 1->0, go to DONE. enable, mode and burst_start are ignored. Serial inputs are sampled live every cycle.
  - DONE: done=1 for exactly one cycle, q holds, next state IDLE. burst_start in DONE is ignored.
- Latency: a burst of N>0 performs its last operation at edge N after the start edge. done is high during the cycle after that edge. With busy included, the start-to-done window is N+1 cycles.
- signal_q_ is always ~signal_q, including during reset.

Decomposition:
- Package shiftregister_pkg:
  - mode constants: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR, MODE_LOAD.
  - state encoding: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module shiftregister_step: combinational next-value function (q, mode, serial inputs, preset -> next q), parametrised by WIDTH. The top level holds the register, the FSM and the counter.

Test Plan:
- Reset: clear=0 for one edge with preset_enable=1, preset=111111 -> q=000000, signal_q_=111111, busy=0, done=0.
- Shifts: load 101100; mode 001, serial_input_right=1 -> q=110110; mode 010, serial_input_left=0 -> q=101100; serial_output_right=0, serial_output_left=1.
- Rotate and arithmetic shift: q=000001, mode 011 -> q=100000; q=100100, mode 101 -> q=110010; mode 111 with enable=1 -> q unchanged.
- Burst: q=000001, mode 100, burst_start with count=3 -> busy=1 for 3 cycles, q=000010, 000100, 001000; done=1 on the next cycle, then IDLE; mode changes during RUN have no effect.
- Burst abort: during RUN of count=5, after 2 operations assert preset_enable with preset=111111 -> q=111111 on that edge, busy=0, done never pulses.
- Edge cases: burst_count=0 -> done pulses one cycle after start, q unchanged. Mid-burst clear=0 -> q=0, state IDLE, done=0.
